// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: FSM states, grant sources and line geometry.
package arbiter_types;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } arb_state_t;

   typedef enum logic {
      ARB_SRC_I,
      ARB_SRC_D
   } arb_src_t;

   localparam int LINE_BEATS = 4;

endpackage

// File: rtl/cache_arbiter_line_buffer.sv
// Line buffer for the cache arbiter. Supports whole-line load, per-beat insert
// and per-beat extract, and clears on asynchronous reset.
module line_buffer #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int BEATS   = LINE_W / BURST_W,
   parameter int IDX_W   = $clog2(BEATS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [LINE_W-1:0]  load_data,
   input  logic               ins_en,
   input  logic [IDX_W-1:0]   ins_idx,
   input  logic [BURST_W-1:0] ins_data,
   input  logic [IDX_W-1:0]   ext_idx,
   output logic [BURST_W-1:0] ext_data,
   output logic [LINE_W-1:0]  line
);

   logic [BURST_W-1:0] beats [BEATS];

   // One register per beat so that each slice has exactly one driver.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
         logic [BURST_W-1:0] beat_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               beat_reg <= '0;
            end else if (load) begin
               beat_reg <= load_data[gi*BURST_W +: BURST_W];
            end else if (ins_en && ins_idx == IDX_W'(gi)) begin
               beat_reg <= ins_data;
            end
         end

         assign beats[gi] = beat_reg;
         assign line[gi*BURST_W +: BURST_W] = beat_reg;
      end
   endgenerate

   assign ext_data = beats[ext_idx];

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one burst memory port.
// Define CACHE_ARB_RR_EN for round-robin arbitration; otherwise D-cache has fixed priority.
module cache_arbiter
   import arbiter_types::*;
#(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_read,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic [LINE_W-1:0]  i_rdata,
   output logic               i_resp,
   input  logic               d_read,
   input  logic               d_write,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [LINE_W-1:0]  d_wdata,
   output logic [LINE_W-1:0]  d_rdata,
   output logic               d_resp,
   output logic               pmem_read,
   output logic               pmem_write,
   output logic [ADDR_W-1:0]  pmem_addr,
   output logic [BURST_W-1:0] pmem_wdata,
   input  logic [BURST_W-1:0] pmem_rdata,
   input  logic               pmem_resp
);

   localparam int CNT_W = $clog2(LINE_BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

   arb_state_t        state_reg;
   arb_src_t          src_reg;
   logic [CNT_W-1:0]  beat_reg;
   logic [ADDR_W-1:0] addr_reg;

   logic               req_i;
   logic               req_d;
   logic               grant_d;
   logic               line_load;
   logic               line_ins;
   logic [BURST_W-1:0] beat_data;
   logic [LINE_W-1:0]  line;

   assign req_i = i_read;
   assign req_d = d_read | d_write;

`ifdef CACHE_ARB_RR_EN
   arb_src_t last_reg;

   // On contention the side that did not win last time takes the grant.
   assign grant_d = req_d && (!req_i || last_reg == ARB_SRC_I);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_reg <= ARB_SRC_I;
      end else if (state_reg == IDLE && (req_i || req_d)) begin
         last_reg <= grant_d ? ARB_SRC_D : ARB_SRC_I;
      end
   end
`else
   assign grant_d = req_d;
`endif

   assign line_load = (state_reg == IDLE) && grant_d && d_write;
   assign line_ins  = (state_reg == RD_BURST) && pmem_resp;

   line_buffer #(
      .LINE_W  (LINE_W),
      .BURST_W (BURST_W),
      .BEATS   (LINE_BEATS),
      .IDX_W   (CNT_W)
   ) u_line_buffer (
      .clk       (clk),
      .rst       (rst),
      .load      (line_load),
      .load_data (d_wdata),
      .ins_en    (line_ins),
      .ins_idx   (beat_reg),
      .ins_data  (pmem_rdata),
      .ext_idx   (beat_reg),
      .ext_data  (beat_data),
      .line      (line)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         src_reg   <= ARB_SRC_I;
         beat_reg  <= '0;
         addr_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               beat_reg <= '0;
               if (req_i || req_d) begin
                  src_reg   <= grant_d ? ARB_SRC_D : ARB_SRC_I;
                  addr_reg  <= (grant_d ? d_addr : i_addr) & LINE_MASK;
                  state_reg <= (grant_d && d_write) ? WR_BURST : RD_BURST;
               end
            end
            RD_BURST, WR_BURST: begin
               // Counter wraps to 0 on the final beat, ready for the next burst.
               if (pmem_resp) begin
                  beat_reg <= beat_reg + 1'b1;
                  if (beat_reg == LAST_BEAT) begin
                     state_reg <= DONE;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign pmem_read  = (state_reg == RD_BURST);
   assign pmem_write = (state_reg == WR_BURST);
   assign pmem_addr  = addr_reg;
   assign pmem_wdata = pmem_write ? beat_data : '0;

   assign i_resp  = (state_reg == DONE) && (src_reg == ARB_SRC_I);
   assign d_resp  = (state_reg == DONE) && (src_reg == ARB_SRC_D);
   assign i_rdata = line;
   assign d_rdata = line;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: table of line transactions plus reset and
// hold-past-resp sequences, with a burst-memory responder and a response scoreboard.
`timescale 1ns/1ps
module tb_cache_arbiter;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int ADDR_W  = 32;

`ifdef CACHE_ARB_RR_EN
   localparam bit RR_BUILD = 1'b1;
`else
   localparam bit RR_BUILD = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               i_read;
   logic [ADDR_W-1:0]  i_addr;
   logic [LINE_W-1:0]  i_rdata;
   logic               i_resp;
   logic               d_read;
   logic               d_write;
   logic [ADDR_W-1:0]  d_addr;
   logic [LINE_W-1:0]  d_wdata;
   logic [LINE_W-1:0]  d_rdata;
   logic               d_resp;
   logic               pmem_read;
   logic               pmem_write;
   logic [ADDR_W-1:0]  pmem_addr;
   logic [BURST_W-1:0] pmem_wdata;
   logic [BURST_W-1:0] pmem_rdata;
   logic               pmem_resp;

   cache_arbiter #(
      .LINE_W  (LINE_W),
      .BURST_W (BURST_W),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_read     (i_read),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_resp     (i_resp),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_resp     (d_resp),
      .pmem_read  (pmem_read),
      .pmem_write (pmem_write),
      .pmem_addr  (pmem_addr),
      .pmem_wdata (pmem_wdata),
      .pmem_rdata (pmem_rdata),
      .pmem_resp  (pmem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              ir;
      logic              dr;
      logic              dw;
      logic [ADDR_W-1:0] ia;
      logic [ADDR_W-1:0] da;
      int                stall;
      logic [7:0]        salt;
      logic [LINE_W-1:0] wd;
      logic              fix_d;
      logic              rr_d;
   } vec_t;

   typedef struct {
      logic              src_d;
      logic              is_write;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] rdata;
   } exp_t;

   exp_t               sb_q[$];
   logic [BURST_W-1:0] wr_cap[$];
   logic [BURST_W-1:0] rd_beats [4];
   int                 stall_cfg = 0;
   int                 burst_cnt = 0;
   int                 wr_cycles = 0;
   int                 n_txn = 0;
   int                 n_vec = 0;
   int                 n_miss = 0;
   logic               act_prev = 1'b0;
   vec_t               vt [9];

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Burst memory: optional stall cycles before each beat, captures write beats.
   initial begin
      int mb;
      int wc;
      mb = 0;
      wc = 0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst || !(pmem_read || pmem_write)) begin
            pmem_resp = 1'b0;
            mb = 0;
            wc = 0;
         end else begin
            if (pmem_resp) begin
               mb++;
               wc = 0;
            end
            if (wc < stall_cfg) begin
               pmem_resp = 1'b0;
               wc++;
            end else begin
               pmem_resp  = 1'b1;
               pmem_rdata = rd_beats[mb % 4];
               if (pmem_write) wr_cap.push_back(pmem_wdata);
            end
         end
      end
   end

   // Monitor: burst bookkeeping, address/direction checks, response scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if ((pmem_read || pmem_write) && !act_prev) burst_cnt++;
            if (pmem_write) wr_cycles++;
            if ((pmem_read || pmem_write) && sb_q.size() != 0) begin
               check("pmem_addr", LINE_W'(pmem_addr), LINE_W'(sb_q[0].addr));
               check("pmem_dir", LINE_W'(pmem_write), LINE_W'(sb_q[0].is_write));
            end
            if (i_resp || d_resp) begin
               check("resp_exclusive", LINE_W'(i_resp & d_resp), LINE_W'(0));
               check("resp_expected", LINE_W'(sb_q.size() != 0), LINE_W'(1));
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  check("resp_src", LINE_W'(d_resp), LINE_W'(e.src_d));
                  if (!e.is_write) check("rdata", d_resp ? d_rdata : i_rdata, e.rdata);
                  $display("txn %0d: src=%s %s addr=%h", n_txn, d_resp ? "D" : "I",
                           e.is_write ? "write" : "read", e.addr);
                  n_txn++;
               end
            end
         end
         act_prev = pmem_read || pmem_write;
      end
   end

   task automatic drop_requests();
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
   endtask

   task automatic run_txn(input vec_t v, input bit hold);
      exp_t e;
      int   cycles;
      int   b0;
      int   w0;
      int   exp_lat;
      e.src_d    = RR_BUILD ? v.rr_d : v.fix_d;
      e.is_write = e.src_d && v.dw;
      e.addr     = (e.src_d ? v.da : v.ia) & 32'hFFFF_FFE0;
      for (int k = 0; k < 4; k++) rd_beats[k] = {16{4'(k + 1)}} ^ {8{v.salt}};
      e.rdata    = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
      stall_cfg  = v.stall;
      exp_lat    = 1 + 4 * (v.stall + 1);
      wr_cap.delete();
      b0 = burst_cnt;
      w0 = wr_cycles;
      @(negedge clk);
      sb_q.push_back(e);
      i_read  = v.ir;
      d_read  = v.dr;
      d_write = v.dw;
      i_addr  = v.ia;
      d_addr  = v.da;
      d_wdata = v.wd;
      cycles  = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!(i_resp || d_resp) && cycles < 400);
      check("latency", LINE_W'(cycles), LINE_W'(exp_lat));
      if (!hold) drop_requests();
      @(negedge clk);
      check("resp_pulse", LINE_W'({i_resp, d_resp}), LINE_W'(0));
      drop_requests();
      repeat (6) @(negedge clk);
      check("burst_count", LINE_W'(burst_cnt - b0), LINE_W'(1));
      check("write_cycles", LINE_W'(wr_cycles - w0), e.is_write ? LINE_W'(exp_lat - 1) : LINE_W'(0));
      if (e.is_write) begin
         check("write_beat_count", LINE_W'(wr_cap.size()), LINE_W'(4));
         for (int k = 0; k < 4 && k < wr_cap.size(); k++)
            check("write_beat", LINE_W'(wr_cap[k]), LINE_W'(v.wd[k*BURST_W +: BURST_W]));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      exp_t e;
      int   b0;
      rst = 1'b1;
      drop_requests();
      i_addr  = '0;
      d_addr  = '0;
      d_wdata = '0;
      for (int k = 0; k < 4; k++) rd_beats[k] = '0;

      //        ir    dr    dw    i_addr        d_addr        stall salt   wdata fix_d rr_d
      vt[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h8000_0040, 2, 8'h00, '0, 1'b1, 1'b1};
      vt[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000, 0, 8'h00, '0, 1'b0, 1'b0};
      vt[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3008, 0, 8'h5A, '0, 1'b1, 1'b1};
      vt[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_2040, 32'h0000_3040, 1, 8'hA5, '0, 1'b1, 1'b0};
      vt[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_2080, 32'h0000_3080, 0, 8'h3C, '0, 1'b1, 1'b1};
      vt[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h4000_01FF, 0, 8'h00, '0, 1'b1, 1'b1};
      vt[6] = '{1'b1, 1'b0, 1'b0, 32'h1234_567F, 32'h0000_0000, 1, 8'h77, '0, 1'b0, 1'b0};
      vt[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 0, 8'h99, '0, 1'b1, 1'b1};
      vt[8] = '{1'b1, 1'b0, 1'b1, 32'h0000_5000, 32'h0000_6000, 0, 8'hC3, '0, 1'b1, 1'b0};
      vt[0].wd = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
      for (int w = 0; w < 8; w++) begin
         vt[5].wd[32*w +: 32] = $urandom;
         vt[8].wd[32*w +: 32] = $urandom;
      end

      #12;
      check("reset_ctrl", LINE_W'({pmem_read, pmem_write, i_resp, d_resp}), LINE_W'(0));
      check("reset_pmem_addr", LINE_W'(pmem_addr), LINE_W'(0));
      check("reset_pmem_wdata", LINE_W'(pmem_wdata), LINE_W'(0));
      check("reset_i_rdata", i_rdata, LINE_W'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_txn(vt[i], 1'b0);

      // Reset after beat 2 of a read: partial line dropped, no response.
      rv = '{1'b1, 1'b0, 1'b0, 32'h0000_7010, 32'h0, 0, 8'h10, '0, 1'b0, 1'b0};
      for (int k = 0; k < 4; k++) rd_beats[k] = {16{4'(k + 1)}} ^ {8{rv.salt}};
      stall_cfg = 0;
      e.src_d = 1'b0;
      e.is_write = 1'b0;
      e.addr = 32'h0000_7000;
      e.rdata = '0;
      @(negedge clk);
      sb_q.push_back(e);
      i_read = 1'b1;
      i_addr = rv.ia;
      repeat (4) @(posedge clk);
      #1 check("pre_reset_read", LINE_W'(pmem_read), LINE_W'(1));
      #1 rst = 1'b1;
      sb_q.delete();
      #1;
      check("midrst_ctrl", LINE_W'({pmem_read, pmem_write, i_resp, d_resp}), LINE_W'(0));
      check("midrst_pmem_addr", LINE_W'(pmem_addr), LINE_W'(0));
      check("midrst_pmem_wdata", LINE_W'(pmem_wdata), LINE_W'(0));
      check("midrst_i_rdata", i_rdata, LINE_W'(0));
      check("midrst_d_rdata", d_rdata, LINE_W'(0));
      drop_requests();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      b0 = burst_cnt;
      repeat (10) @(negedge clk);
      check("no_burst_after_reset", LINE_W'(burst_cnt - b0), LINE_W'(0));
      run_txn(rv, 1'b0);

      // Requester keeps i_read up through the edge after its resp.
      run_txn(vt[1], 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
